// File: rtl/hazard_unit_mc_pkg.sv
// Shared constants for the multi-cycle hazard controller.
//   FWD_*      : E-stage operand mux select encodings
//   hz_state_e : cache-miss FSM state encoding
package hazard_pkg;

  localparam logic [1:0] FWD_NONE = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_W    = 2'b01;  // operand from W-stage result
  localparam logic [1:0] FWD_M    = 2'b10;  // operand from M-stage ALU result

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_IMISS = 2'd1,
    ST_DMISS = 2'd2
  } hz_state_e;

endpackage

// File: rtl/hazard_unit_mc_if.sv
// Pipeline <-> hazard-unit signal bundle.
//   master : datapath side, drives stage information, receives controls
//   slave  : hazard unit, consumes stage information, drives Stall*/Flush*,
//            Forward*E, MdDone and MissCycles
interface hazard_unit_mc_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic              ICacheMiss, DCacheMiss;
  logic              BranchE, JalrE, JalD;
  logic [REG_AW-1:0] Rs1D, Rs2D, RdD;
  logic [1:0]        RegReadD;
  logic              RegWriteD, MdStartD;
  logic [REG_AW-1:0] Rs1E, Rs2E, RdE;
  logic [1:0]        RegReadE;
  logic              MemToRegE, MdStartE;
  logic [REG_AW-1:0] RdM;
  logic [2:0]        RegWriteM;
  logic              MemToRegM;
  logic [REG_AW-1:0] RdW;
  logic [2:0]        RegWriteW;
  logic              StallF, FlushF, StallD, FlushD, StallE, FlushE;
  logic              StallM, FlushM, StallW, FlushW;
  logic [1:0]        Forward1E, Forward2E;
  logic              MdDone;
  logic [CNT_W-1:0]  MissCycles;

  modport master (
    output ICacheMiss, DCacheMiss, BranchE, JalrE, JalD,
           Rs1D, Rs2D, RdD, RegReadD, RegWriteD, MdStartD,
           Rs1E, Rs2E, RdE, RegReadE, MemToRegE, MdStartE,
           RdM, RegWriteM, MemToRegM, RdW, RegWriteW,
    input  StallF, FlushF, StallD, FlushD, StallE, FlushE,
           StallM, FlushM, StallW, FlushW,
           Forward1E, Forward2E, MdDone, MissCycles
  );

  modport slave (
    input  ICacheMiss, DCacheMiss, BranchE, JalrE, JalD,
           Rs1D, Rs2D, RdD, RegReadD, RegWriteD, MdStartD,
           Rs1E, Rs2E, RdE, RegReadE, MemToRegE, MdStartE,
           RdM, RegWriteM, MemToRegM, RdW, RegWriteW,
    output StallF, FlushF, StallD, FlushD, StallE, FlushE,
           StallM, FlushM, StallW, FlushW,
           Forward1E, Forward2E, MdDone, MissCycles
  );
endinterface

// File: rtl/hazard_unit_mc_md_scoreboard.sv
// Single-entry scoreboard for the multi-cycle mul/div unit.
//   clk_i/rst_i      : clock, async active-high reset
//   frz_i            : freeze (data-cache miss), holds all state
//   issue_i          : mul/div leaves E this cycle; issue_rd_i is its Rd
//   rs1_i/rs2_i/rd_i : D-stage register numbers; reg_read_i = {rs1,rs2} used
//   reg_write_i      : D instruction writes rd_i; md_start_i : D is mul/div
//   done_o           : result written this cycle
//   hazard_o         : D must stall (RAW/WAW on pending Rd, or unit busy)
module md_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int MD_LAT = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              frz_i,
  input  logic              issue_i,
  input  logic [REG_AW-1:0] issue_rd_i,
  input  logic [REG_AW-1:0] rs1_i,
  input  logic [REG_AW-1:0] rs2_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic [1:0]        reg_read_i,
  input  logic              reg_write_i,
  input  logic              md_start_i,
  output logic              done_o,
  output logic              hazard_o
);
  localparam int CW = (MD_LAT > 2) ? $clog2(MD_LAT) : 1;

  logic              busy_q, busy_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              raw;

  // Done is suppressed while frozen so a freeze delays it cycle for cycle.
  assign done_o = busy_q & (cnt_q == '0) & ~frz_i;

  assign raw = busy_q & (rd_q != '0) &
               ((reg_read_i[1] & (rs1_i == rd_q)) |
                (reg_read_i[0] & (rs2_i == rd_q)) |
                (reg_write_i   & (rd_i  == rd_q)));

  // Busy covers the done cycle too: the dependent is released the cycle
  // after, reading the freshly written value through the write-first file.
  assign hazard_o = raw | (md_start_i & busy_q);

  always_comb begin
    busy_d = busy_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    if (!frz_i) begin
      if (busy_q && cnt_q != '0) cnt_d = cnt_q - CW'(1);
      if (done_o) busy_d = 1'b0;
      if (issue_i) begin
        busy_d = 1'b1;
        rd_d   = issue_rd_i;
        cnt_d  = CW'(MD_LAT - 1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q <= 1'b0;
      rd_q   <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard controller for the 5-stage F/D/E/M/W pipeline with cache-miss
// freeze, redirect-during-fetch-miss tracking and a mul/div scoreboard.
//   CPU_CLK : clock (rising edge)
//   CpuRst  : async active-high reset
//   hz      : slave side of hazard_unit_mc_if (stage info in, controls out)
module hazard_unit_mc
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int MD_LAT = 8,
  parameter int CNT_W  = 32
) (
  input  logic             CPU_CLK,
  input  logic             CpuRst,
  hazard_unit_mc_if.slave  hz
);
  hz_state_e        state_q;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic stall_f, flush_f, stall_d, flush_d, stall_e, flush_e;
  logic stall_m, flush_m, stall_w, flush_w;
  logic load_use, sb_hazard, sb_done, data_stall;
  logic redir_e, redir_take, md_issue;
  logic [1:0] fwd1, fwd2;

  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic              used,
    input logic [REG_AW-1:0] rd_m,
    input logic [2:0]        we_m,
    input logic              mem_m,
    input logic [REG_AW-1:0] rd_w,
    input logic [2:0]        we_w
  );
    logic [1:0] s;
    s = FWD_NONE;
    if (used && rs != '0) begin
      // A load in M has no data yet; it can only come from W next cycle.
      if (rs == rd_m && we_m != '0 && !mem_m) s = FWD_M;
      else if (rs == rd_w && we_w != '0)      s = FWD_W;
    end
    return s;
  endfunction

  assign load_use = hz.MemToRegE & (hz.RdE != '0) &
                    ((hz.RegReadD[1] & (hz.Rs1D == hz.RdE)) |
                     (hz.RegReadD[0] & (hz.Rs2D == hz.RdE)));
  assign data_stall = load_use | sb_hazard;
  assign redir_e    = hz.BranchE | hz.JalrE;
  // JalD only redirects when the D instruction is actually moving on.
  assign redir_take = redir_e | (hz.JalD & ~data_stall);
  assign md_issue   = hz.MdStartE & ~stall_e & ~flush_e & ~CpuRst;

  md_scoreboard #(.REG_AW(REG_AW), .MD_LAT(MD_LAT)) u_sb (
    .clk_i      (CPU_CLK),
    .rst_i      (CpuRst),
    .frz_i      (hz.DCacheMiss),
    .issue_i    (md_issue),
    .issue_rd_i (hz.RdE),
    .rs1_i      (hz.Rs1D),
    .rs2_i      (hz.Rs2D),
    .rd_i       (hz.RdD),
    .reg_read_i (hz.RegReadD),
    .reg_write_i(hz.RegWriteD),
    .md_start_i (hz.MdStartD),
    .done_o     (sb_done),
    .hazard_o   (sb_hazard)
  );

  // Priority mux: dcache freeze > E redirect > data stall > JalD > imiss.
  always_comb begin
    stall_f = 1'b0; flush_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
    stall_e = 1'b0; flush_e = 1'b0; stall_m = 1'b0; flush_m = 1'b0;
    stall_w = 1'b0; flush_w = 1'b0;
    if (CpuRst) begin
      flush_f = 1'b1; flush_d = 1'b1; flush_e = 1'b1;
      flush_m = 1'b1; flush_w = 1'b1;
    end else if (hz.DCacheMiss) begin
      stall_f = 1'b1; stall_d = 1'b1; stall_e = 1'b1;
      stall_m = 1'b1; stall_w = 1'b1;
    end else begin
      if (redir_e) begin
        flush_d = 1'b1; flush_e = 1'b1;
      end else if (data_stall) begin
        stall_f = 1'b1; stall_d = 1'b1; flush_e = 1'b1;
      end else if (hz.JalD) begin
        flush_d = 1'b1;
      end else if (hz.ICacheMiss) begin
        stall_f = 1'b1; flush_d = 1'b1;
      end
      // The fetch that was in flight when the PC redirected returns stale.
      if (pend_q && !hz.ICacheMiss) flush_d = 1'b1;
    end
  end

  always_comb begin
    fwd1 = FWD_NONE;
    fwd2 = FWD_NONE;
    if (!CpuRst) begin
      fwd1 = fwd_sel(hz.Rs1E, hz.RegReadE[1], hz.RdM, hz.RegWriteM,
                     hz.MemToRegM, hz.RdW, hz.RegWriteW);
      fwd2 = fwd_sel(hz.Rs2E, hz.RegReadE[0], hz.RdM, hz.RegWriteM,
                     hz.MemToRegM, hz.RdW, hz.RegWriteW);
    end
  end

  always_comb begin
    pend_d = pend_q;
    if (!hz.DCacheMiss) begin
      if (hz.ICacheMiss && redir_take) pend_d = 1'b1;
      else if (!hz.ICacheMiss)         pend_d = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if ((hz.ICacheMiss || hz.DCacheMiss) && cnt_q != '1)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CPU_CLK or posedge CpuRst) begin
    if (CpuRst) begin
      state_q <= ST_RUN;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      case (state_q)
        ST_RUN: begin
          if (hz.DCacheMiss)      state_q <= ST_DMISS;
          else if (hz.ICacheMiss) state_q <= ST_IMISS;
        end
        ST_IMISS: begin
          if (hz.DCacheMiss)       state_q <= ST_DMISS;
          else if (!hz.ICacheMiss) state_q <= ST_RUN;
        end
        ST_DMISS: if (!hz.DCacheMiss) state_q <= ST_RUN;
        default:  state_q <= ST_RUN;
      endcase
    end
  end

  assign hz.StallF     = stall_f;
  assign hz.FlushF     = flush_f;
  assign hz.StallD     = stall_d;
  assign hz.FlushD     = flush_d;
  assign hz.StallE     = stall_e;
  assign hz.FlushE     = flush_e;
  assign hz.StallM     = stall_m;
  assign hz.FlushM     = flush_m;
  assign hz.StallW     = stall_w;
  assign hz.FlushW     = flush_w;
  assign hz.Forward1E  = fwd1;
  assign hz.Forward2E  = fwd2;
  assign hz.MdDone     = sb_done & ~CpuRst;
  assign hz.MissCycles = cnt_q;
endmodule
